signal_stats: RTL

Parametrised windowed signal-statistics engine for the ADC-to-VGA path. It takes a qualified ADC sample stream and tracks the minimum, maximum, peak-to-peak amplitude and DC offset over a fixed window of accepted samples. It also counts hysteresis-qualified rising crossings of the previous window's DC offset, which serve as the frequency measurement. Results are registered once per window with a one-cycle strobe, ready for the display/overlay logic.

---
 rtl/signal_stats_pkg.sv | 27 ++
 rtl/stats_schmitt.sv | 56 +++++
 rtl/signal_stats.sv | 99 +++++++++
 3 files changed

// File: rtl/signal_stats_pkg.sv
// Shared constants, threshold-bound helpers and Schmitt state type for the
// windowed signal-statistics engine.
package signal_stats_pkg;

  localparam int unsigned DefaultDataW    = 12;
  localparam int unsigned DefaultWindow   = 50_000_000;
  localparam int unsigned DefaultHyst     = 8;
  localparam int unsigned DefaultMidscale = 1 << (DefaultDataW - 1);

  function automatic int unsigned midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  // Written so that a + b is never formed when it could exceed lim.
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned lim);
    if (b > lim || a > lim - b) return lim;
    return a + b;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : 32'd0;
  endfunction

  typedef enum logic {LOW, HIGH} schmitt_state_t;

endpackage

// File: rtl/stats_schmitt.sv
// Hysteresis crossing detector: counts LOW->HIGH transitions of accepted
// samples around a movable threshold.
module stats_schmitt
  import signal_stats_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned HYST   = DefaultHyst,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] thr,
  input  logic [DATA_W-1:0] sample,
  input  logic              accept,
  input  logic              clear,
  output logic              rise,
  output logic [CNT_W-1:0]  acc
);

  localparam int unsigned CodeMax = (32'd1 << DATA_W) - 32'd1;

  schmitt_state_t    state_q, state_d;
  logic [DATA_W-1:0] hi, lo;
  logic [CNT_W-1:0]  acc_q;

  assign hi = DATA_W'(sat_add(32'(thr), HYST, CodeMax));
  assign lo = DATA_W'(sat_sub(32'(thr), HYST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOW;
      acc_q   <= '0;
    end else if (accept) begin
      state_q <= state_d;
      // The closing sample's own rise is published by the top via rise.
      acc_q   <= clear ? '0 : acc_q + CNT_W'(rise);
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        LOW:     if (sample >= hi) state_d = HIGH;
        HIGH:    if (sample <= lo) state_d = LOW;
        default: state_d = LOW;
      endcase
    end
  end

  always_comb begin
    rise = accept && (state_q == LOW) && (state_d == HIGH);
    acc  = acc_q;
  end

endmodule

// File: rtl/signal_stats.sv
// Windowed min/max/amplitude/DC-offset tracker with a Schmitt crossing count,
// published once per window of accepted samples.
module signal_stats
  import signal_stats_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned WINDOW = DefaultWindow,
  parameter int unsigned HYST   = DefaultHyst,
  parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              hold,
  output logic [DATA_W-1:0] amp,
  output logic [DATA_W-1:0] dc_offset,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] min_out,
  output logic [CNT_W-1:0]  cross_count,
  output logic              stats_valid
);

  localparam int unsigned     IdxW    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WINDOW - 1);

  logic [IdxW-1:0]   idx_q;
  logic [DATA_W-1:0] max_q, min_q, thr_q;
  logic [DATA_W-1:0] max_nxt, min_nxt, dc_nxt;
  logic [DATA_W:0]   sum;
  logic              close, rise;
  logic [CNT_W-1:0]  acc;

  always_comb begin
    max_nxt = (sample > max_q) ? sample : max_q;
    min_nxt = (sample < min_q) ? sample : min_q;
    sum     = {1'b0, max_nxt} + {1'b0, min_nxt};
    dc_nxt  = sum[DATA_W:1];
    close   = sample_valid && (idx_q == LastIdx);
  end

  stats_schmitt #(
    .DATA_W (DATA_W),
    .HYST   (HYST),
    .CNT_W  (CNT_W)
  ) u_schmitt (
    .clk    (clk),
    .rst_n  (rst_n),
    .thr    (thr_q),
    .sample (sample),
    .accept (sample_valid),
    .clear  (close),
    .rise   (rise),
    .acc    (acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      max_q <= '0;
      min_q <= '1;
      thr_q <= DATA_W'(midscale(DATA_W));
    end else if (sample_valid) begin
      if (close) begin
        idx_q <= '0;
        max_q <= '0;
        min_q <= '1;
        // Threshold follows the window's DC offset even while publishing is held.
        thr_q <= dc_nxt;
      end else begin
        idx_q <= idx_q + IdxW'(1);
        max_q <= max_nxt;
        min_q <= min_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      amp         <= '0;
      dc_offset   <= '0;
      max_out     <= '0;
      min_out     <= '0;
      cross_count <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (close && !hold) begin
        amp         <= max_nxt - min_nxt;
        dc_offset   <= dc_nxt;
        max_out     <= max_nxt;
        min_out     <= min_nxt;
        cross_count <= acc + CNT_W'(rise);
        stats_valid <= 1'b1;
      end
    end
  end

endmodule
